// File: rtl/game_pkg.sv
// Shared definitions for the per-object game blocks: state encoding,
// screen geometry and the LFSR polynomial used by every random source.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_FLIGHT = 3'd3,
    ST_SLICED = 3'd4,
    ST_RETIRE = 3'd5
  } state_t;

  localparam logic [9:0]  SCREEN_W  = 10'd640;
  localparam logic [8:0]  SCREEN_H  = 9'd480;
  // Fibonacci taps 16,14,13,11 (bit indices 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances every clock, restarts at SEED.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [15:0] out
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) out <= SEED;
    else       out <= lfsr_step(out);
  end

endmodule

// File: rtl/fruit_launch_scheduler.sv
// Life-cycle sequencer for one flying object: cooldown, random launch,
// gravity on move ticks, slice / off-screen retirement.
module fruit_launch_scheduler #(
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter logic [7:0]  COOLDOWN = 8'd40,
  parameter logic [3:0]  GRAV_DIV = 4'd6,
  parameter logic [8:0]  VY0_BASE = 9'd8,
  parameter logic [8:0]  VY_MAX   = 9'd12,
  parameter logic [8:0]  SCREEN_H = 9'd480,
  parameter logic [8:0]  SPAWN_Y  = 9'd470
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic       moveclk,
  input  logic [8:0] posy,
  input  logic       hit,
  output logic       objLoad,
  output logic [9:0] initposx,
  output logic [8:0] initposy,
  output logic [9:0] vx,
  output logic [8:0] vy,
  output logic       dx,
  output logic       dy,
  output logic       active,
  output logic       sliced,
  output logic       missed
);
  import game_pkg::*;

  state_t      state_reg, state_next;
  logic        mv_q, tick;
  logic [15:0] lfsr;
  logic [1:0]  lfsr_unused;
  logic [7:0]  cool_reg, cool_next;
  logic [3:0]  grav_reg, grav_next;
  logic [9:0]  posx_reg, posx_next, vx_reg, vx_next, launch_x;
  logic [8:0]  vy_reg, vy_next, posy_init_reg;
  logic        dx_reg, dx_next, dy_reg, dy_next;
  logic        load_reg, load_next, sliced_reg, sliced_next;
  logic        missed_reg, missed_next, active_reg, active_next;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rstn (rstn),
    .out  (lfsr)
  );

  assign lfsr_unused = lfsr[15:14];
  assign tick        = moveclk & ~mv_q;
  assign launch_x    = 10'd64 + {1'b0, lfsr[8:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      mv_q          <= 1'b0;
      cool_reg      <= '0;
      grav_reg      <= '0;
      posx_reg      <= '0;
      posy_init_reg <= SPAWN_Y;
      vx_reg        <= '0;
      vy_reg        <= '0;
      dx_reg        <= 1'b0;
      dy_reg        <= 1'b0;
      load_reg      <= 1'b0;
      sliced_reg    <= 1'b0;
      missed_reg    <= 1'b0;
      active_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mv_q          <= moveclk;
      cool_reg      <= cool_next;
      grav_reg      <= grav_next;
      posx_reg      <= posx_next;
      posy_init_reg <= SPAWN_Y;
      vx_reg        <= vx_next;
      vy_reg        <= vy_next;
      dx_reg        <= dx_next;
      dy_reg        <= dy_next;
      load_reg      <= load_next;
      sliced_reg    <= sliced_next;
      missed_reg    <= missed_next;
      active_reg    <= active_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cool_next   = cool_reg;
    grav_next   = grav_reg;
    posx_next   = posx_reg;
    vx_next     = vx_reg;
    vy_next     = vy_reg;
    dx_next     = dx_reg;
    dy_next     = dy_reg;
    load_next   = 1'b0;
    sliced_next = 1'b0;
    missed_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_WAIT;
          cool_next  = '0;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (tick) begin
          if (cool_reg == COOLDOWN - 8'd1) state_next = ST_LAUNCH;
          else                             cool_next  = cool_reg + 8'd1;
        end
      end
      ST_LAUNCH: begin
        posx_next  = launch_x;
        dx_next    = (launch_x < (SCREEN_W >> 1));
        vx_next    = {8'b0, lfsr[10:9]};
        vy_next    = VY0_BASE + {6'b0, lfsr[13:11]};
        dy_next    = 1'b0;
        grav_next  = '0;
        load_next  = 1'b1;
        state_next = ST_FLIGHT;
      end
      ST_FLIGHT, ST_SLICED: begin
        if (tick) begin
          if (grav_reg == GRAV_DIV - 4'd1) begin
            grav_next = '0;
            // rising objects decelerate through zero, then fall up to VY_MAX
            if (!dy_reg) begin
              if (vy_reg == '0) dy_next = 1'b1;
              else              vy_next = vy_reg - 9'd1;
            end else begin
              vy_next = (vy_reg >= VY_MAX) ? VY_MAX : vy_reg + 9'd1;
            end
          end else begin
            grav_next = grav_reg + 4'd1;
          end
        end
        // off-screen wins over a same-cycle slice
        if (dy_reg && (posy >= SCREEN_H)) begin
          state_next  = ST_RETIRE;
          missed_next = (state_reg == ST_FLIGHT);
          vx_next     = '0;
          vy_next     = '0;
        end else if ((state_reg == ST_FLIGHT) && hit) begin
          state_next  = ST_SLICED;
          sliced_next = 1'b1;
          vx_next     = '0;
          dy_next     = 1'b1;
          vy_next     = (vy_reg == '0) ? 9'd1 : vy_reg;
        end
      end
      ST_RETIRE: begin
        if (enable) begin
          state_next = ST_WAIT;
          cool_next  = '0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    active_next = (state_next == ST_FLIGHT) || (state_next == ST_SLICED);
  end

  assign objLoad  = load_reg;
  assign initposx = posx_reg;
  assign initposy = posy_init_reg;
  assign vx       = vx_reg;
  assign vy       = vy_reg;
  assign dx       = dx_reg;
  assign dy       = dy_reg;
  assign active   = active_reg;
  assign sliced   = sliced_reg;
  assign missed   = missed_reg;

endmodule

// File: tb/tb_fruit_launch_scheduler.sv
// Self-checking bench for fruit_launch_scheduler: table of in-flight scenarios
// plus a gravity scoreboard and an asynchronous-reset sequence.
module tb_fruit_launch_scheduler;

  localparam int GD   = 6;
  localparam int VMAX = 12;

  logic       clk = 1'b0;
  logic       rstn, enable, moveclk, hit;
  logic [8:0] posy;
  logic       objLoad, dx, dy, active, sliced, missed;
  logic [9:0] initposx, vx;
  logic [8:0] initposy, vy;

  always #5 clk = ~clk;

  fruit_launch_scheduler dut (
    .clk      (clk),
    .rstn     (rstn),
    .enable   (enable),
    .moveclk  (moveclk),
    .posy     (posy),
    .hit      (hit),
    .objLoad  (objLoad),
    .initposx (initposx),
    .initposy (initposy),
    .vx       (vx),
    .vy       (vy),
    .dx       (dx),
    .dy       (dy),
    .active   (active),
    .sliced   (sliced),
    .missed   (missed)
  );

  typedef struct {
    bit         fall;
    logic [8:0] posy;
    bit         hit;
    bit         exp_missed;
    bit         exp_sliced;
    bit         exp_active;
    bit         en_off;
  } vec_t;

  vec_t rows[5];

  int n_checks = 0, n_fail = 0;
  int ph = 0, g = 0, ticks_since = 0, ticks_launch = 0, vy0 = 0, sat_steps = 0;
  int mvy = 0;
  bit mdy = 0, grav_track = 0, flip_seen = 0;
  logic [9:0] exp_q[$];

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // one clock: drive moveclk at the falling edge, sample after the next one
  task automatic cyc();
    bit t;
    logic [9:0] e;
    t = 0;
    ph++;
    if (ph == 8) begin
      ph = 0;
      moveclk = ~moveclk;
      t = moveclk;
    end
    if (t && grav_track) begin
      g++;
      if (g == GD) begin
        g = 0;
        if (!mdy) begin
          if (mvy == 0) mdy = 1;
          else          mvy--;
        end else begin
          if (mvy >= VMAX) sat_steps++;
          mvy = (mvy + 1 > VMAX) ? VMAX : mvy + 1;
        end
        exp_q.push_back({mdy, 9'(mvy)});
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (t) begin
      ticks_since++;
      ticks_launch++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("grav_vy", int'(vy), int'(e[8:0]));
      chk("grav_dy", int'(dy), int'(e[9]));
    end
    if (grav_track && !flip_seen && dy === 1'b1) begin
      flip_seen = 1;
      chk("flip_ticks", ticks_launch, GD * (vy0 + 1));
    end
  endtask

  task automatic wait_launch(bit track);
    int n;
    n = 0;
    while (objLoad !== 1'b1 && n < 1000) begin
      cyc();
      n++;
    end
    chk("launch_seen", int'(objLoad === 1'b1), 1);
    chk("cooldown_ticks", ticks_since, 40);
    chk("launch_initposy", int'(initposy), 470);
    chk("launch_dy", int'(dy), 0);
    chk("launch_active", int'(active), 1);
    chk("launch_vy_range", int'(vy >= 9'd8 && vy <= 9'd15), 1);
    chk("launch_x_range", int'(initposx >= 10'd64 && initposx <= 10'd575), 1);
    chk("launch_dx_rule", int'(dx), int'(initposx < 10'd320));
    chk("launch_vx_range", int'(vx <= 10'd3), 1);
    mvy = int'(vy);
    vy0 = int'(vy);
    mdy = 0;
    g = 0;
    ticks_launch = 0;
    flip_seen = 0;
    sat_steps = 0;
    grav_track = track;
  endtask

  task automatic idle_window(int cycles);
    int loads, act;
    loads = 0;
    act = 0;
    for (int k = 0; k < cycles; k++) begin
      cyc();
      if (objLoad) loads++;
      if (active) act++;
    end
    chk("idle_no_load", loads, 0);
    chk("idle_inactive", act, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, miss_cnt;
    //              fall posy  hit miss slic act off
    rows[0] = '{1, 9'd480, 1, 1, 0, 0, 0};  // falling, off-screen beats hit
    rows[1] = '{0, 9'd480, 0, 0, 0, 1, 0};  // rising: bottom row is not off-screen
    rows[2] = '{0, 9'd200, 1, 0, 1, 1, 0};  // slice in flight
    rows[3] = '{1, 9'd479, 0, 0, 0, 1, 1};  // last visible row, then enable drop
    rows[4] = '{0, 9'd200, 0, 0, 0, 1, 0};  // quiet cycle

    rstn = 1'b0; enable = 1'b0; moveclk = 1'b0; hit = 1'b0; posy = 9'd200;
    repeat (3) @(negedge clk);
    chk("rst_objLoad", int'(objLoad), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_vx", int'(vx), 0);
    chk("rst_vy", int'(vy), 0);
    chk("rst_dx", int'(dx), 0);
    chk("rst_dy", int'(dy), 0);
    chk("rst_initposx", int'(initposx), 0);
    chk("rst_initposy", int'(initposy), 470);
    chk("rst_sliced", int'(sliced), 0);
    chk("rst_missed", int'(missed), 0);
    rstn = 1'b1;
    idle_window(400);

    enable = 1'b1;
    cyc();
    ticks_since = 0;

    for (int i = 0; i < 5; i++) begin
      wait_launch(rows[i].fall);
      cyc();
      chk("objload_width", int'(objLoad), 0);
      if (rows[i].fall) begin
        n = 0;
        while (!(mdy && mvy == VMAX && sat_steps >= 2) && n < 5000) begin
          cyc();
          n++;
        end
        chk("fall_done", int'(n < 5000), 1);
        chk("flip_seen", int'(flip_seen), 1);
        grav_track = 0;
      end
      posy = rows[i].posy;
      hit  = rows[i].hit;
      cyc();
      chk($sformatf("row%0d_missed", i), int'(missed), int'(rows[i].exp_missed));
      chk($sformatf("row%0d_sliced", i), int'(sliced), int'(rows[i].exp_sliced));
      chk($sformatf("row%0d_active", i), int'(active), int'(rows[i].exp_active));
      hit = 1'b0;
      if (rows[i].exp_sliced) begin
        chk("slice_vx", int'(vx), 0);
        chk("slice_dy", int'(dy), 1);
        chk("slice_vy_min", int'(vy >= 9'd1), 1);
        cyc();
        chk("sliced_width", int'(sliced), 0);
      end
      if (rows[i].en_off) enable = 1'b0;
      posy = 9'd480;
      miss_cnt = 0;
      n = 0;
      while (active && n < 4000) begin
        cyc();
        n++;
        if (missed) miss_cnt++;
      end
      chk($sformatf("row%0d_retired", i), int'(active), 0);
      chk($sformatf("row%0d_cleanup_missed", i), miss_cnt,
          (rows[i].exp_missed || rows[i].exp_sliced) ? 0 : 1);
      chk("retire_vx", int'(vx), 0);
      chk("retire_vy", int'(vy), 0);
      posy = 9'd200;
      cyc();
      ticks_since = 0;
      if (rows[i].en_off) begin
        idle_window(1000);
        enable = 1'b1;
        cyc();
        ticks_since = 0;
      end
    end

    // asynchronous reset while the freshly launched object is in flight
    wait_launch(0);
    #2 rstn = 1'b0;
    #1;
    chk("async_active", int'(active), 0);
    chk("async_objLoad", int'(objLoad), 0);
    chk("async_vy", int'(vy), 0);
    chk("async_vx", int'(vx), 0);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    idle_window(800);
    chk("post_rst_initposy", int'(initposy), 470);
    enable = 1'b1;
    cyc();
    ticks_since = 0;
    wait_launch(0);
    cyc();
    chk("objload_width", int'(objLoad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
